ptcalc_mul_pipe_sat: RTL and testbench

Parametrised, pipelined signed multiplier for the pt-calculation datapath. It is the successor to the fixed single-cycle 21s x 12s -> 33 multiplier wrappers.
- Adds configurable operand/result widths and pipeline depth.
- Adds an arithmetic right-shift with optional round-half-up and optional saturation to the output width.
- Adds a valid/ready handshake with clock-enable.
- Sits between pt-calc coefficient/segment stages wherever a scaled fixed-point product is consumed downstream.

---
 rtl/ptcalc_mul_pkg.sv | 20 ++
 rtl/ptcalc_mul_round_sat.sv | 41 ++++
 rtl/ptcalc_mul_pipe_sat.sv | 132 +++++++++++++
 tb/tb_ptcalc_mul_pipe_sat.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptcalc_mul_pkg.sv
// Shared constants and helpers for the pt-calc pipelined signed multiplier.
package ptcalc_mul_pkg;

    localparam int MAX_DIN0_WIDTH = 27;
    localparam int MAX_DIN1_WIDTH = 18;
    localparam int MAX_NUM_STAGE  = 4;

    function automatic int prod_width(input int a, input int b);
        return a + b;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/ptcalc_mul_round_sat.sv
// Combinational scaling of a full-width signed product: arithmetic shift with
// optional round-half-up, then saturate or wrap to the output width.
module ptcalc_mul_round_sat
    import ptcalc_mul_pkg::*;
#(
    parameter int PW         = 33,
    parameter int DOUT_WIDTH = 33,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 1
) (
    input  logic [PW-1:0]         prod,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam logic signed [63:0] MAX64 = sat_max(DOUT_WIDTH);
    localparam logic signed [63:0] MIN64 = sat_min(DOUT_WIDTH);
    localparam logic signed [PW:0] RMAX  = MAX64[PW:0];
    localparam logic signed [PW:0] RMIN  = MIN64[PW:0];
    localparam int                 RPOS  = (ROUND != 0 && SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [PW:0]        RND   = (ROUND != 0 && SHIFT > 0) ?
                                           ({{PW{1'b0}}, 1'b1} << RPOS) : '0;

    logic signed [PW:0] ext;
    logic signed [PW:0] sum;
    logic signed [PW:0] r;

    // One extra bit of headroom keeps the rounding addend from overflowing.
    always_comb begin
        ext  = {prod[PW-1], prod};
        sum  = ext + $signed(RND);
        r    = sum >>> SHIFT;
        ovf  = (r > RMAX) || (r < RMIN);
        dout = r[DOUT_WIDTH-1:0];
        if (SAT != 0 && ovf) begin
            dout = (r > RMAX) ? RMAX[DOUT_WIDTH-1:0] : RMIN[DOUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ptcalc_mul_pipe_sat.sv
// Pipelined signed multiplier with scaling, saturation and a valid/ready
// handshake; NUM_STAGE registers from operand capture to registered result.
module ptcalc_mul_pipe_sat
    import ptcalc_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 21,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 33,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    logic                  adv;
    logic [NUM_STAGE-1:0]  vld;
    logic [NUM_STAGE:0]    vchain;
    logic [DIN0_WIDTH-1:0] mul_a;
    logic [DIN1_WIDTH-1:0] mul_b;
    logic signed [PW-1:0]  mul_p;
    logic [PW-1:0]         prod_final;
    logic [DOUT_WIDTH-1:0] rs_dout;
    logic                  rs_ovf;

    // vchain[0] is the incoming valid, vchain[NUM_STAGE] the output stage.
    assign vchain    = {vld, in_valid};
    assign out_valid = vchain[NUM_STAGE];
    assign adv       = ce && (!out_valid || out_ready);
    assign in_ready  = adv;

    assign mul_p = PW'($signed(mul_a)) * PW'($signed(mul_b));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else if (adv) begin
            vld <= vchain[NUM_STAGE-1:0];
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_stage1
            assign mul_a      = din0;
            assign mul_b      = din1;
            assign prod_final = mul_p;
        end else begin : g_opreg
            logic [DIN0_WIDTH-1:0] a_q;
            logic [DIN1_WIDTH-1:0] b_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= din0;
                    b_q <= din1;
                end
            end

            assign mul_a = a_q;
            assign mul_b = b_q;

            if (NUM_STAGE == 2) begin : g_stage2
                assign prod_final = mul_p;
            end else begin : g_prodreg
                logic [PW-1:0] p_q;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        p_q <= '0;
                    end else if (adv) begin
                        p_q <= mul_p;
                    end
                end

                if (NUM_STAGE == 3) begin : g_stage3
                    assign prod_final = p_q;
                end else begin : g_stage4
                    logic [PW-1:0] p2_q;

                    always_ff @(posedge clk or posedge reset) begin
                        if (reset) begin
                            p2_q <= '0;
                        end else if (adv) begin
                            p2_q <= p_q;
                        end
                    end

                    assign prod_final = p2_q;
                end
            end
        end
    endgenerate

    ptcalc_mul_round_sat #(
        .PW         (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .ROUND      (ROUND),
        .SAT        (SAT)
    ) u_round_sat (
        .prod (prod_final),
        .dout (rs_dout),
        .ovf  (rs_ovf)
    );

    // Only valid items load the result, so dout holds across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            ovf  <= 1'b0;
        end else if (adv && vchain[NUM_STAGE-1]) begin
            dout <= rs_dout;
            ovf  <= rs_ovf;
        end
    end

endmodule

// File: tb/tb_ptcalc_mul_pipe_sat.sv
// Directed bench for ptcalc_mul_pipe_sat: defaults, scaled 16-bit variants,
// and NUM_STAGE 1/2/4 variants all driven from one shared input set.
module tb_ptcalc_mul_pipe_sat;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [20:0] din0 = '0;
    logic [11:0] din1 = '0;

    logic        def_ir, def_ov, def_ovf;
    logic [32:0] def_dout;
    logic        r16s_ir, r16s_ov, r16s_ovf;
    logic [15:0] r16s_dout;
    logic        r16w_ir, r16w_ov, r16w_ovf;
    logic [15:0] r16w_dout;
    logic        s1_ir, s1_ov, s1_ovf;
    logic [32:0] s1_dout;
    logic        s2_ir, s2_ov, s2_ovf;
    logic [32:0] s2_dout;
    logic        s4_ir, s4_ov, s4_ovf;
    logic [32:0] s4_dout;

    logic        ovl [6];
    logic        ofl [6];
    logic [32:0] dvl [6];

    int          checks = 0;
    int          errors = 0;

    int          lat  [6];
    logic [32:0] gotd [6];
    logic        gotf [6];

    int vec_a [6] = '{12345, -54321, 1048575, -1048576, 777, -1};
    int vec_b [6] = '{-7, 321, 2047, -2048, 0, -1};

    logic [32:0] rx_val [$];
    int          rx_cyc [$];
    int          ref_cyc [$];
    int          gate_err;
    int          hold_err;
    int          stall_cycles;

    always #5 clk = ~clk;

    ptcalc_mul_pipe_sat u_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(def_ir),
        .din0(din0), .din1(din1), .out_valid(def_ov), .out_ready(out_ready),
        .dout(def_dout), .ovf(def_ovf)
    );

    ptcalc_mul_pipe_sat #(.DOUT_WIDTH(16), .SHIFT(4), .ROUND(1), .SAT(1)) u_r16s (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(r16s_ir),
        .din0(din0), .din1(din1), .out_valid(r16s_ov), .out_ready(out_ready),
        .dout(r16s_dout), .ovf(r16s_ovf)
    );

    ptcalc_mul_pipe_sat #(.DOUT_WIDTH(16), .SHIFT(4), .ROUND(1), .SAT(0)) u_r16w (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(r16w_ir),
        .din0(din0), .din1(din1), .out_valid(r16w_ov), .out_ready(out_ready),
        .dout(r16w_dout), .ovf(r16w_ovf)
    );

    ptcalc_mul_pipe_sat #(.NUM_STAGE(1)) u_s1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(s1_ir),
        .din0(din0), .din1(din1), .out_valid(s1_ov), .out_ready(out_ready),
        .dout(s1_dout), .ovf(s1_ovf)
    );

    ptcalc_mul_pipe_sat #(.NUM_STAGE(2)) u_s2 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(s2_ir),
        .din0(din0), .din1(din1), .out_valid(s2_ov), .out_ready(out_ready),
        .dout(s2_dout), .ovf(s2_ovf)
    );

    ptcalc_mul_pipe_sat #(.NUM_STAGE(4)) u_s4 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(s4_ir),
        .din0(din0), .din1(din1), .out_valid(s4_ov), .out_ready(out_ready),
        .dout(s4_dout), .ovf(s4_ovf)
    );

    assign ovl[0] = def_ov;   assign ofl[0] = def_ovf;   assign dvl[0] = def_dout;
    assign ovl[1] = r16s_ov;  assign ofl[1] = r16s_ovf;  assign dvl[1] = {17'b0, r16s_dout};
    assign ovl[2] = r16w_ov;  assign ofl[2] = r16w_ovf;  assign dvl[2] = {17'b0, r16w_dout};
    assign ovl[3] = s1_ov;    assign ofl[3] = s1_ovf;    assign dvl[3] = s1_dout;
    assign ovl[4] = s2_ov;    assign ofl[4] = s2_ovf;    assign dvl[4] = s2_dout;
    assign ovl[5] = s4_ov;    assign ofl[5] = s4_ovf;    assign dvl[5] = s4_dout;

    // Every default-config product fits in 33 signed bits, so it is the result.
    function automatic logic [32:0] exp_prod(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[32:0];
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        ce        = 1'b1;
        out_ready = 1'b1;
        din0      = '0;
        din1      = '0;
        #1 reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset  = 1'b0;
    endtask

    // One item into an empty pipe; records first-valid cycle and result per DUT.
    task automatic run_single(input int a, input int b);
        din0      = 21'(a);
        din1      = 12'(b);
        in_valid  = 1'b1;
        ce        = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            lat[k]  = 0;
            gotd[k] = '0;
            gotf[k] = 1'b0;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            for (int k = 0; k < 6; k++) begin
                if (ovl[k] && lat[k] == 0) begin
                    lat[k]  = cyc;
                    gotd[k] = dvl[k];
                    gotf[k] = ofl[k];
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Streams n vectors into u_def with optional ce-low and out_ready-low windows.
    task automatic run_stream(input int n, input int ce_lo, input int ce_hi,
                              input int rdy_lo, input int rdy_hi);
        int          sent;
        logic        acc;
        logic        ov_b;
        logic        hold_b;
        logic [32:0] d_b;
        sent = 0;
        rx_val.delete();
        rx_cyc.delete();
        gate_err     = 0;
        hold_err     = 0;
        stall_cycles = 0;
        for (int c = 0; c < 60 && rx_val.size() < n; c++) begin
            in_valid  = (sent < n);
            din0      = (sent < n) ? 21'(vec_a[sent]) : '0;
            din1      = (sent < n) ? 12'(vec_b[sent]) : '0;
            ce        = !(c >= ce_lo && c <= ce_hi);
            out_ready = !(c >= rdy_lo && c <= rdy_hi);
            #1;
            ov_b   = def_ov;
            d_b    = def_dout;
            hold_b = !ce || (ov_b && !out_ready);
            if (hold_b && def_ir) gate_err++;
            if (ce && out_ready && !def_ir) gate_err++;
            if (ce && ov_b && !out_ready) stall_cycles++;
            if (ce && ov_b && out_ready) begin
                rx_val.push_back(d_b);
                rx_cyc.push_back(c);
            end
            acc = in_valid && def_ir;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (hold_b && (def_ov !== ov_b || def_dout !== d_b)) hold_err++;
        end
        in_valid  = 1'b0;
        ce        = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (def_ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", def_ov);
        end
        checks++;
        if (def_dout !== 33'd0) begin
            errors++;
            $display("[TB] FAIL reset_dout: got %0h expected 0", def_dout);
        end
        checks++;
        if (def_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ovf: got %b expected 0", def_ovf);
        end
        do_reset();
        out_ready = 1'b0;
        #1;
        checks++;
        if (def_ir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_empty_pipe: got %b expected 1", def_ir);
        end
        ce = 1'b0;
        #1;
        checks++;
        if (def_ir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_ce_low: got %b expected 0", def_ir);
        end
        ce        = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_default_product();
        int exp_lat [6] = '{3, 3, 3, 1, 2, 4};
        do_reset();
        run_single(-1048576, -2048);
        checks++;
        if (gotd[0] !== 33'h0_8000_0000 || gotf[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL default_max_product: got %0h/%b expected 80000000/0", gotd[0], gotf[0]);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lat[k] != exp_lat[k]) begin
                errors++;
                $display("[TB] FAIL latency_dut%0d: got %0d expected %0d", k, lat[k], exp_lat[k]);
            end
        end
        for (int k = 3; k < 6; k++) begin
            checks++;
            if (gotd[k] !== 33'h0_8000_0000) begin
                errors++;
                $display("[TB] FAIL stage_variant_dut%0d: got %0h expected 80000000", k, gotd[k]);
            end
        end
    endtask

    task automatic test_round_sat();
        int          va [9] = '{100, 1000000, -1000000, 8, -8, 524272, 524280, -524288, -524297};
        int          vb [9] = '{-3, 2047, 2047, 1, 1, 1, 1, 1, 1};
        logic [15:0] es [9] = '{16'hFFED, 16'h7FFF, 16'h8000, 16'h0001, 16'h0000,
                                16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        logic [15:0] ew [9] = '{16'hFFED, 16'h2BDC, 16'hD424, 16'h0001, 16'h0000,
                                16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
        logic        eo [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_single(va[i], vb[i]);
            checks++;
            if (gotd[1][15:0] !== es[i] || gotf[1] !== eo[i]) begin
                errors++;
                $display("[TB] FAIL sat_vec%0d: got %0h/%b expected %0h/%b", i, gotd[1][15:0], gotf[1], es[i], eo[i]);
            end
            checks++;
            if (gotd[2][15:0] !== ew[i] || gotf[2] !== eo[i]) begin
                errors++;
                $display("[TB] FAIL wrap_vec%0d: got %0h/%b expected %0h/%b", i, gotd[2][15:0], gotf[2], ew[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_stream(6, -1, -2, 4, 8);
        checks++;
        if (rx_val.size() != 6) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d expected 6", rx_val.size());
        end
        for (int i = 0; i < 6 && i < rx_val.size(); i++) begin
            checks++;
            if (rx_val[i] !== exp_prod(vec_a[i], vec_b[i])) begin
                errors++;
                $display("[TB] FAIL bp_item%0d: got %0h expected %0h", i, rx_val[i], exp_prod(vec_a[i], vec_b[i]));
            end
        end
        checks++;
        if (stall_cycles == 0 || gate_err != 0 || hold_err != 0) begin
            errors++;
            $display("[TB] FAIL bp_stall: stalls %0d gate %0d hold %0d expected >0/0/0", stall_cycles, gate_err, hold_err);
        end
    endtask

    task automatic test_ce();
        do_reset();
        run_stream(6, -1, -2, -1, -2);
        ref_cyc = rx_cyc;
        checks++;
        if (ref_cyc.size() != 6 || ref_cyc[5] != ref_cyc[0] + 5) begin
            errors++;
            $display("[TB] FAIL throughput: got %0d outputs", ref_cyc.size());
        end
        do_reset();
        run_stream(6, 2, 4, -1, -2);
        checks++;
        if (rx_val.size() != 6) begin
            errors++;
            $display("[TB] FAIL ce_count: got %0d expected 6", rx_val.size());
        end
        for (int i = 0; i < 6 && i < rx_val.size() && i < ref_cyc.size(); i++) begin
            checks++;
            if (rx_val[i] !== exp_prod(vec_a[i], vec_b[i]) || rx_cyc[i] != ref_cyc[i] + 3) begin
                errors++;
                $display("[TB] FAIL ce_item%0d: got %0h@%0d expected %0h@%0d", i, rx_val[i], rx_cyc[i],
                         exp_prod(vec_a[i], vec_b[i]), ref_cyc[i] + 3);
            end
        end
        checks++;
        if (gate_err != 0 || hold_err != 0) begin
            errors++;
            $display("[TB] FAIL ce_freeze: gate %0d hold %0d expected 0/0", gate_err, hold_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din0     = 21'(vec_a[i]);
            din1     = 12'(vec_b[i]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (def_ov !== 1'b1 || def_dout !== exp_prod(vec_a[0], vec_b[0])) begin
            errors++;
            $display("[TB] FAIL inflight_head: got %b/%0h expected 1/%0h", def_ov, def_dout, exp_prod(vec_a[0], vec_b[0]));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (def_ov !== 1'b0 || def_dout !== 33'd0 || def_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b/%0h/%b expected 0/0/0", def_ov, def_dout, def_ovf);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        run_single(vec_a[3], vec_b[3]);
        checks++;
        if (lat[0] != 3 || gotd[0] !== exp_prod(vec_a[3], vec_b[3])) begin
            errors++;
            $display("[TB] FAIL post_reset_item: got %0h@%0d expected %0h@3", gotd[0], lat[0], exp_prod(vec_a[3], vec_b[3]));
        end
    endtask

    initial begin
        test_reset();
        test_default_product();
        test_round_sat();
        test_backpressure();
        test_ce();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
